// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - shares one sram-like bus between the fetch and data ports of the CPU
module cpu_sram_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     inst_sram_req,
   input  logic                     inst_sram_wr,
   input  logic [1:0]               inst_sram_size,
   input  logic [31:0]              inst_sram_addr,
   input  logic [31:0]              inst_sram_wdata,
   output logic                     inst_sram_addrok,
   output logic                     inst_sram_dataok,
   output logic [31:0]              inst_sram_rdata,
   input  logic                     data_sram_req,
   input  logic                     data_sram_wr,
   input  logic [1:0]               data_sram_size,
   input  logic [3:0]               data_sram_wstrb,
   input  logic [31:0]              data_sram_addr,
   input  logic [31:0]              data_sram_wdata,
   output logic                     data_sram_addrok,
   output logic                     data_sram_dataok,
   output logic [31:0]              data_sram_rdata,
   output logic                     sram_req,
   output logic                     sram_wr,
   output logic [1:0]               sram_size,
   output logic [3:0]               sram_wstrb,
   output logic [31:0]              sram_addr,
   output logic [31:0]              sram_wdata,
   input  logic                     sram_addrok,
   input  logic                     sram_dataok,
   input  logic [31:0]              sram_rdata,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     resp_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   L_DEPTH = DEPTH[PW:0];
   localparam logic [SW-1:0] L_LIMIT = STARVE_LIMIT[SW-1:0];
   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   typedef enum logic {ST_FREE, ST_LOCKED} lock_state_t;

   lock_state_t      r_state;
   lock_state_t      w_state_nxt;
   logic             r_lock_id;
   logic [DEPTH-1:0] r_fifo;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_count;
   logic [SW-1:0]    r_starve;
   logic             r_resp_err;

   logic             w_room;
   logic             w_own_valid;
   logic             w_own_id;
   logic             w_is_inst;
   logic             w_is_data;
   logic             w_push;
   logic             w_pop;
   logic             w_head;
   logic             w_unused;

   assign w_unused = ^inst_sram_wdata;
   assign w_room   = (r_count != L_DEPTH);

   // A full FIFO blocks the bus outright, even while a locked master waits.
   always_comb begin
      w_own_valid = 1'b0;
      w_own_id    = ID_INST;
      if (resetn && w_room) begin
         if (r_state == ST_LOCKED) begin
            w_own_valid = 1'b1;
            w_own_id    = r_lock_id;
         end else if (data_sram_req && !(r_starve == L_LIMIT && inst_sram_req)) begin
            w_own_valid = 1'b1;
            w_own_id    = ID_DATA;
         end else if (inst_sram_req) begin
            w_own_valid = 1'b1;
            w_own_id    = ID_INST;
         end
      end
   end

   assign w_is_inst = w_own_valid && (w_own_id == ID_INST);
   assign w_is_data = w_own_valid && (w_own_id == ID_DATA);

   always_comb begin
      sram_req   = 1'b0;
      sram_wr    = 1'b0;
      sram_size  = 2'b0;
      sram_wstrb = 4'b0;
      sram_addr  = 32'b0;
      sram_wdata = 32'b0;
      if (w_is_data) begin
         sram_req   = data_sram_req;
         sram_wr    = data_sram_wr;
         sram_size  = data_sram_size;
         sram_wstrb = data_sram_wstrb;
         sram_addr  = data_sram_addr;
         sram_wdata = data_sram_wdata;
      end else if (w_is_inst) begin
         sram_req   = inst_sram_req;
         sram_wr    = inst_sram_wr;
         sram_size  = inst_sram_size;
         sram_addr  = inst_sram_addr;
      end
   end

   assign w_push = sram_req && sram_addrok;
   assign w_pop  = resetn && sram_dataok && (r_count != '0);
   assign w_head = r_fifo[r_rptr];

   assign inst_sram_addrok = w_push && (w_own_id == ID_INST);
   assign data_sram_addrok = w_push && (w_own_id == ID_DATA);
   assign inst_sram_dataok = w_pop && (w_head == ID_INST);
   assign data_sram_dataok = w_pop && (w_head == ID_DATA);
   assign inst_sram_rdata  = resetn ? sram_rdata : 32'b0;
   assign data_sram_rdata  = resetn ? sram_rdata : 32'b0;
   assign outstanding      = r_count;
   assign resp_err         = r_resp_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FREE:   if (sram_req && !sram_addrok) w_state_nxt = ST_LOCKED;
         ST_LOCKED: if (w_push) w_state_nxt = ST_FREE;
         default:   w_state_nxt = ST_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_FREE;
         r_lock_id <= ID_INST;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_FREE && w_state_nxt == ST_LOCKED) r_lock_id <= w_own_id;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fifo  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_own_id;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Counts only cycles where fetch is asking and somebody else holds (or nobody is given) the bus.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starve <= '0;
      end else if (!inst_sram_req || inst_sram_addrok) begin
         r_starve <= '0;
      end else if (!w_is_inst && r_starve != L_LIMIT) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_resp_err <= 1'b0;
      end else if (sram_dataok && r_count == '0) begin
         r_resp_err <= 1'b1;
      end
   end

endmodule
